serial_comparator: RTL and testbench
====================================

# serial_comparator

Parametrised multi-cycle magnitude comparator that resolves two WIDTH-bit operands DIGIT bits per clock, MSB slice first, with early termination on the first differing slice. It is the clocked, signed-capable successor to the team's single-bit combinational comparator and keeps its one-hot a_less_b / a_equal_b / a_greater_b result encoding. It sits behind a start/busy/done handshake so wide compares can share one narrow datapath inside sorting and threshold logic.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits compared per cycle; 1 ≤ DIGIT ≤ WIDTH.
- NSLICE (derived, not overridable), WIDTH/DIGIT.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request a compare; sampled only when busy=0.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse when the result flags update.
- a_less_b  output  1  result flag A<B.
- a_equal_b  output  1  result flag A==B.
- a_greater_b  output  1  result flag A>B.
- slices  output  $clog2(NSLICE)+1  number of slices examined in the last compare, 1..NSLICE.

## Operation
- States: IDLE, SCAN.
- IDLE: when start=1, capture a, b, and signed_mode. Go to SCAN, set busy=1, and load slice counter = 0.
  - If signed_mode=1, invert bit WIDTH-1 of both captured operands. The signed compare then reduces to an unsigned compare.
- SCAN, each cycle, compare the top DIGIT bits of the A and B shift registers (unsigned):
  - Slices differ: set exactly one of a_less_b / a_greater_b. Set slices = counter+1, pulse done, and return to IDLE (early exit).
  - Slices equal and counter = NSLICE-1: set a_equal_b=1, slices = NSLICE, pulse done, and return to IDLE.
  - Slices equal otherwise: shift both registers left by DIGIT, increment the counter, and stay in SCAN.
- Result flags are exactly one-hot after the first completed compare.
  - The flags and slices hold their previous values while busy, and hold after done until the next done.
- start while busy=1 is ignored. The captured operands are not disturbed.
- Operand inputs may change freely after the capture edge.

## Timing
- Reset (rst_n=0, asynchronous, immediate): state=IDLE, busy=0, done=0, a_less_b=0, a_equal_b=0, a_greater_b=0, slices=0. Internal registers are cleared.
- Reset mid-SCAN aborts the compare: no done pulse, and the flags are cleared to 0.
- Start accepted at edge E0: busy=1 from E0. With k = index of the first differing slice (1 = MSB slice), or NSLICE if the operands are equal:
  - the flags, slices, and done=1 are registered at edge E0+k;
  - busy=0 from E0+k.
- Latency is k cycles: minimum 1, maximum NSLICE.
- done is high for exactly one cycle, E0+k to E0+k+1. busy is already 0 during that cycle.
- Back-to-back: start=1 during the done cycle is accepted at edge E0+k+1. There are no dead cycles between compares.
- DIGIT=WIDTH degenerates to a fixed 1-cycle compare. done still pulses and slices=1.

## Test plan
All scenarios use WIDTH=16, DIGIT=4.
- Unsigned equal: a=16'h1234, b=16'h1234, signed_mode=0. Required: done at E0+4, a_equal_b=1, slices=4, busy high for exactly 4 cycles.
- Unsigned MSB differ: a=16'h8000, b=16'h7FFF, signed_mode=0. Required: done at E0+1, a_greater_b=1, slices=1.
- Signed: the same operands with signed_mode=1 (-32768 vs 32767). Required: done at E0+1, a_less_b=1.
  - Also a=16'hFFFF, b=16'hFFFE, signed. Required: a_greater_b=1, slices=4.
- Mid-word differ: a=16'h12A0, b=16'h12B0, unsigned. Required: done at E0+3, a_less_b=1, slices=3.
  - Pulse start again at E0+1 with different operands: it is ignored and the result is unchanged.
  - A start held during the done cycle launches the next compare with no gap.
- Reset mid-operation: start a compare with a=16'h1234, b=16'h1234, then drop rst_n at E0+2. Required:
  - busy, done, and all flags go to 0 immediately;
  - no done appears after release;
  - the next start (a=16'h0001, b=16'h0002) yields a_less_b=1 at E0'+4.

Source files
------------

// File: rtl/serial_comparator.sv
// Multi-cycle magnitude comparator: DIGIT bits per cycle, MSB slice first.
// Early exit on the first differing slice; signed mode via MSB inversion.
module serial_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              signed_mode,
  input  logic [WIDTH-1:0]                  a,
  input  logic [WIDTH-1:0]                  b,
  output logic                              busy,
  output logic                              done,
  output logic                              a_less_b,
  output logic                              a_equal_b,
  output logic                              a_greater_b,
  output logic [$clog2(WIDTH/DIGIT):0]      slices
);

  localparam int NSLICE = WIDTH / DIGIT;
  localparam int CW     = $clog2(NSLICE) + 1;
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);
  localparam logic [CW-1:0] FULL = CW'(NSLICE);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sa, sa_n;
  logic [WIDTH-1:0] sb, sb_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [CW-1:0]    slices_n;
  logic             done_n, lt_n, eq_n, gt_n;
  logic [DIGIT-1:0] ta, tb;
  logic [WIDTH-1:0] smask;

  assign ta    = sa[WIDTH-1 -: DIGIT];
  assign tb    = sb[WIDTH-1 -: DIGIT];
  assign smask = signed_mode ? MSB : '0;
  assign busy  = (state == SCAN);

  always_comb begin
    state_n  = state;
    sa_n     = sa;
    sb_n     = sb;
    cnt_n    = cnt;
    done_n   = 1'b0;
    lt_n     = a_less_b;
    eq_n     = a_equal_b;
    gt_n     = a_greater_b;
    slices_n = slices;
    unique case (state)
      IDLE: begin
        if (start) begin
          // Flipping the sign bit maps two's-complement order onto unsigned order
          sa_n    = a ^ smask;
          sb_n    = b ^ smask;
          cnt_n   = '0;
          state_n = SCAN;
        end
      end
      SCAN: begin
        unique case (1'b1)
          (ta != tb): begin
            lt_n     = (ta < tb);
            eq_n     = 1'b0;
            gt_n     = (ta > tb);
            slices_n = cnt + 1'b1;
            done_n   = 1'b1;
            state_n  = IDLE;
          end
          (ta == tb && cnt == LAST): begin
            lt_n     = 1'b0;
            eq_n     = 1'b1;
            gt_n     = 1'b0;
            slices_n = FULL;
            done_n   = 1'b1;
            state_n  = IDLE;
          end
          default: begin
            sa_n  = sa << DIGIT;
            sb_n  = sb << DIGIT;
            cnt_n = cnt + 1'b1;
          end
        endcase
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sa          <= '0;
      sb          <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      a_less_b    <= 1'b0;
      a_equal_b   <= 1'b0;
      a_greater_b <= 1'b0;
      slices      <= '0;
    end else begin
      state       <= state_n;
      sa          <= sa_n;
      sb          <= sb_n;
      cnt         <= cnt_n;
      done        <= done_n;
      a_less_b    <= lt_n;
      a_equal_b   <= eq_n;
      a_greater_b <= gt_n;
      slices      <= slices_n;
    end
  end

endmodule

// File: tb/tb_serial_comparator.sv
// Scoreboard bench for serial_comparator (WIDTH=16, DIGIT=4).
// Expected results queued at launch, popped when done pulses.
module tb_serial_comparator;

  localparam int W = 16;
  localparam int D = 4;
  localparam int NS = W / D;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          signed_mode = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy, done;
  logic          a_less_b, a_equal_b, a_greater_b;
  logic [2:0]    slices;

  typedef struct {
    logic lt;
    logic eq;
    logic gt;
    int   k;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic l_lt = 1'b0, l_eq = 1'b0, l_gt = 1'b0;

  serial_comparator #(.WIDTH(W), .DIGIT(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .signed_mode(signed_mode), .a(a), .b(b),
    .busy(busy), .done(done),
    .a_less_b(a_less_b), .a_equal_b(a_equal_b),
    .a_greater_b(a_greater_b), .slices(slices)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input logic sm);
    exp_t e;
    logic [W-1:0] d;
    e.lt = sm ? ($signed(x) < $signed(y)) : (x < y);
    e.gt = sm ? ($signed(x) > $signed(y)) : (x > y);
    e.eq = (x == y);
    d = x ^ y;
    e.k = NS;
    for (int i = NS - 1; i >= 0; i--)
      if (d[i*D +: D] != '0) begin
        e.k = NS - i;
        break;
      end
    return e;
  endfunction

  task automatic launch(input logic [W-1:0] x,
                        input logic [W-1:0] y,
                        input logic sm);
    start = 1'b1;
    a = x;
    b = y;
    signed_mode = sm;
    q.push_back(model(x, y, sm));
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    signed_mode = 1'($urandom);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL launch_busy got %b want 1", busy);
    end
  endtask

  task automatic collect(input bit inject,
                         input logic [W-1:0] ia,
                         input logic [W-1:0] ib);
    exp_t e;
    int lat = 0;
    int bc = 0;
    bit seen = 1'b0;
    while (lat < 20 && !seen) begin
      if (busy) begin
        bc++;
        checks++;
        if ({a_less_b, a_equal_b, a_greater_b} !== {l_lt, l_eq, l_gt}) begin
          errors++;
          $display("FAIL hold_flags got %b%b%b want %b%b%b",
                   a_less_b, a_equal_b, a_greater_b, l_lt, l_eq, l_gt);
        end
      end
      if (inject && lat == 0) begin
        start = 1'b1;
        a = ia;
        b = ib;
        signed_mode = 1'b0;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
      seen = done;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout got no done want done within 20");
      if (q.size() > 0) void'(q.pop_front());
      return;
    end
    e = q.pop_front();
    checks++;
    if ({a_less_b, a_equal_b, a_greater_b} !== {e.lt, e.eq, e.gt}) begin
      errors++;
      $display("FAIL flags got %b%b%b want %b%b%b",
               a_less_b, a_equal_b, a_greater_b, e.lt, e.eq, e.gt);
    end
    checks++;
    if (slices !== 3'(e.k)) begin
      errors++;
      $display("FAIL slices got %0d want %0d", slices, e.k);
    end
    checks++;
    if (lat != e.k) begin
      errors++;
      $display("FAIL latency got %0d want %0d", lat, e.k);
    end
    checks++;
    if (bc != e.k) begin
      errors++;
      $display("FAIL busy_cycles got %0d want %0d", bc, e.k);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_in_done got %b want 0", busy);
    end
    l_lt = e.lt;
    l_eq = e.eq;
    l_gt = e.gt;
  endtask

  task automatic check_idle_hold();
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 ||
        {a_less_b, a_equal_b, a_greater_b} !== {l_lt, l_eq, l_gt}) begin
      errors++;
      $display("FAIL after_done got d%b b%b f%b%b%b want d0 b0 f%b%b%b",
               done, busy, a_less_b, a_equal_b, a_greater_b, l_lt, l_eq, l_gt);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, a_less_b, a_equal_b, a_greater_b} !== 5'b0 ||
        slices !== 3'd0) begin
      errors++;
      $display("FAIL reset got %b%b%b%b%b s%0d want 00000 s0",
               busy, done, a_less_b, a_equal_b, a_greater_b, slices);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_unsigned_equal();
    launch(16'h1234, 16'h1234, 1'b0);
    collect(1'b0, '0, '0);
    check_idle_hold();
  endtask

  task automatic test_msb_differ();
    launch(16'h8000, 16'h7FFF, 1'b0);
    collect(1'b0, '0, '0);
  endtask

  task automatic test_signed();
    launch(16'h8000, 16'h7FFF, 1'b1);
    collect(1'b0, '0, '0);
    launch(16'hFFFF, 16'hFFFE, 1'b1);
    collect(1'b0, '0, '0);
  endtask

  task automatic test_back_to_back();
    launch(16'h12A0, 16'h12B0, 1'b0);
    collect(1'b1, 16'hFFFF, 16'h0000);
    start = 1'b1;
    a = 16'h0005;
    b = 16'h0003;
    signed_mode = 1'b0;
    q.push_back(model(16'h0005, 16'h0003, 1'b0));
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept got %b want 1", busy);
    end
    collect(1'b0, '0, '0);
  endtask

  task automatic test_reset_mid();
    bit bad = 1'b0;
    launch(16'h1234, 16'h1234, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, a_less_b, a_equal_b, a_greater_b} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid got %b%b%b%b%b want 00000",
               busy, done, a_less_b, a_equal_b, a_greater_b);
    end
    void'(q.pop_front());
    l_lt = 1'b0;
    l_eq = 1'b0;
    l_gt = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL no_done_after_reset got activity want quiet");
    end
    launch(16'h0001, 16'h0002, 1'b0);
    collect(1'b0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_unsigned_equal();
    test_msb_differ();
    test_signed();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
